// File: rtl/mznm_pkg.sv
// Shared decode-stage definitions: instruction field layout, opcode constants
// and the fetch-sequencing state type.
package mznm_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDD   = 5'b10100;
    localparam logic [1:0]       CLS_NOWB = 2'b11;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } fsm_state_t;

    // Instruction word bits [15:2]; bits [1:0] carry nothing.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [2:0]       rd;
        logic [2:0]       rs1;
        logic [2:0]       rs2;
    } instr_hdr_t;

    function automatic logic dec_wb_en(input logic [OPC_W-1:0] opc);
        return (opc != OP_NOP) && (opc[3:2] != CLS_NOWB);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// One source operand: bypass selection from EX/MEM plus the hazard flag that
// forces the decode stage to stall. DECODE_FWD_EN enables the bypass paths.
module operand_fwd_mux #(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        rs_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              ex_valid_i,
    input  logic              ex_wb_en_i,
    input  logic              ex_is_load_i,
    input  logic [2:0]        ex_rd_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic              mem_valid_i,
    input  logic              mem_wb_en_i,
    input  logic [2:0]        mem_rd_i,
    input  logic [DATA_W-1:0] mem_result_i,
    output logic [DATA_W-1:0] operand_o,
    output logic              hazard_o
);

    logic ex_hit;
    logic mem_hit;
    logic ex_load_hit;

    assign ex_hit      = ex_valid_i && ex_wb_en_i && (ex_rd_i == rs_i);
    assign mem_hit     = mem_valid_i && mem_wb_en_i && (mem_rd_i == rs_i);
    assign ex_load_hit = ex_valid_i && ex_is_load_i && (ex_rd_i == rs_i);

`ifdef DECODE_FWD_EN
    // A load's data is not ready in EX, so it is never a bypass source.
    assign operand_o = (ex_hit && !ex_is_load_i) ? ex_result_i :
                       mem_hit                   ? mem_result_i :
                                                   rf_data_i;
    assign hazard_o  = ex_load_hit;
`else
    logic unused_results;
    assign unused_results = ^{ex_result_i, mem_result_i};

    assign operand_o = rf_data_i;
    assign hazard_o  = ex_load_hit || ex_hit || mem_hit;
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one/two-word instruction sequencing, operand fetch with
// hazard stall, and the ID/EX register. Build macro: DECODE_FWD_EN.
module decode_stage
    import mznm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_word,
    output logic              if_ready,
    output logic [2:0]        rf_addr1,
    output logic [2:0]        rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              ex_valid,
    input  logic              ex_wb_en,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_wb_en,
    input  logic [2:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [OPC_W-1:0]  id_opcode,
    output logic [2:0]        id_rd,
    output logic [DATA_W-1:0] id_op1,
    output logic [DATA_W-1:0] id_op2,
    output logic [15:0]       id_imm,
    output logic              id_wb_en,
    output logic              id_is_load
);

    fsm_state_t        state_q;
    instr_hdr_t        hold_q;
    instr_hdr_t        word_hdr;
    instr_hdr_t        cur_hdr;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hz1;
    logic              hz2;
    logic              completing;
    logic              stall;
    logic              unused_lsbs;

    assign word_hdr    = instr_hdr_t'(if_word[15:2]);
    assign unused_lsbs = ^if_word[1:0];

    // While waiting for the immediate, the held first word owns the read ports.
    assign cur_hdr  = (state_q == S_IMM) ? hold_q : word_hdr;
    assign rf_addr1 = cur_hdr.rs1;
    assign rf_addr2 = cur_hdr.rs2;

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd1 (
        .rs_i         (cur_hdr.rs1),
        .rf_data_i    (rf_data1),
        .ex_valid_i   (ex_valid),
        .ex_wb_en_i   (ex_wb_en),
        .ex_is_load_i (ex_is_load),
        .ex_rd_i      (ex_rd),
        .ex_result_i  (ex_result),
        .mem_valid_i  (mem_valid),
        .mem_wb_en_i  (mem_wb_en),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .operand_o    (op1),
        .hazard_o     (hz1)
    );

    operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd2 (
        .rs_i         (cur_hdr.rs2),
        .rf_data_i    (rf_data2),
        .ex_valid_i   (ex_valid),
        .ex_wb_en_i   (ex_wb_en),
        .ex_is_load_i (ex_is_load),
        .ex_rd_i      (ex_rd),
        .ex_result_i  (ex_result),
        .mem_valid_i  (mem_valid),
        .mem_wb_en_i  (mem_wb_en),
        .mem_rd_i     (mem_rd),
        .mem_result_i (mem_result),
        .operand_o    (op2),
        .hazard_o     (hz2)
    );

    // Hazards only matter for the word that finishes an instruction.
    assign completing = if_valid && ((state_q == S_IMM) || !word_hdr.opcode[4]);
    assign stall      = completing && (cur_hdr.opcode != OP_NOP) && (hz1 || hz2);
    assign if_ready   = !rst && ex_ready && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OP;
            hold_q     <= '0;
            id_valid   <= 1'b0;
            id_opcode  <= '0;
            id_rd      <= '0;
            id_op1     <= '0;
            id_op2     <= '0;
            id_imm     <= '0;
            id_wb_en   <= 1'b0;
            id_is_load <= 1'b0;
        end else if (flush) begin
            state_q  <= S_OP;
            hold_q   <= '0;
            id_valid <= 1'b0;
        end else if (ex_ready) begin
            if (stall || !if_valid) begin
                id_valid <= 1'b0;
            end else if ((state_q == S_OP) && word_hdr.opcode[4]) begin
                state_q  <= S_IMM;
                hold_q   <= word_hdr;
                id_valid <= 1'b0;
            end else begin
                state_q    <= S_OP;
                hold_q     <= '0;
                id_valid   <= 1'b1;
                id_opcode  <= cur_hdr.opcode;
                id_rd      <= cur_hdr.rd;
                id_op1     <= op1;
                id_op2     <= op2;
                id_imm     <= (state_q == S_IMM) ? if_word : 16'h0000;
                id_wb_en   <= dec_wb_en(cur_hdr.opcode);
                id_is_load <= (cur_hdr.opcode == OP_LDD);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a per-cycle reference model of the
// decode rules and hand-computed literal expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_word;
    logic        if_ready;
    logic [2:0]  rf_addr1, rf_addr2;
    logic [15:0] rf_data1, rf_data2;
    logic        ex_valid, ex_wb_en, ex_is_load;
    logic [2:0]  ex_rd;
    logic [15:0] ex_result;
    logic        mem_valid, mem_wb_en;
    logic [2:0]  mem_rd;
    logic [15:0] mem_result;
    logic        flush, ex_ready;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [2:0]  id_rd;
    logic [15:0] id_op1, id_op2, id_imm;
    logic        id_wb_en, id_is_load;

    logic [15:0] rf [8];
    assign rf_data1 = rf[rf_addr1];
    assign rf_data2 = rf[rf_addr2];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_word(if_word), .if_ready(if_ready),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm),
        .id_wb_en(id_wb_en), .id_is_load(id_is_load)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: an instruction is either a single word, or a first word
    // (opcode bit 4 set) waiting for its immediate.
    logic        m_pending = 1'b0;
    logic [15:0] m_first   = 16'h0;
    logic        e_valid = 1'b0, e_wb = 1'b0, e_ld = 1'b0;
    logic [4:0]  e_opc = 5'd0;
    logic [2:0]  e_rd = 3'd0;
    logic [15:0] e_op1 = 16'h0, e_op2 = 16'h0, e_imm = 16'h0;
    logic [15:0] w;
    logic [4:0]  opc;
    logic [2:0]  rs1, rs2;
    logic        m_stall, m_ready, m_done;
    int          cyc = 0;

    function automatic logic dep(input logic [2:0] rs);
        logic d;
        d = ex_valid && ex_is_load && (ex_rd == rs);
`ifndef DECODE_FWD_EN
        d = d || (ex_valid && ex_wb_en && (ex_rd == rs)) || (mem_valid && mem_wb_en && (mem_rd == rs));
`endif
        return d;
    endfunction

    function automatic logic [15:0] operand(input logic [2:0] rs);
`ifdef DECODE_FWD_EN
        if (ex_valid && ex_wb_en && !ex_is_load && (ex_rd == rs)) return ex_result;
        if (mem_valid && mem_wb_en && (mem_rd == rs)) return mem_result;
`endif
        return rf[rs];
    endfunction

    always @(negedge clk) begin
        w       = m_pending ? m_first : if_word;
        opc     = w[15:11];
        rs1     = w[7:5];
        rs2     = w[4:2];
        m_done  = if_valid && (m_pending || !opc[4]);
        m_stall = m_done && (opc != 5'd0) && (dep(rs1) || dep(rs2));
        m_ready = !rst && ex_ready && !m_stall;
        if (cyc > 0) begin
            check("id_regs",
                  64'({id_valid, id_opcode, id_rd, id_wb_en, id_is_load, id_op1, id_op2, id_imm}),
                  64'({e_valid, e_opc, e_rd, e_wb, e_ld, e_op1, e_op2, e_imm}));
            check("handshake", 64'({if_ready, rf_addr1, rf_addr2}), 64'({m_ready, rs1, rs2}));
        end
        cyc++;
        if (rst) begin
            m_pending = 1'b0; m_first = 16'h0;
            e_valid = 1'b0; e_opc = 5'd0; e_rd = 3'd0; e_wb = 1'b0; e_ld = 1'b0;
            e_op1 = 16'h0; e_op2 = 16'h0; e_imm = 16'h0;
        end else if (flush) begin
            m_pending = 1'b0; e_valid = 1'b0;
        end else if (ex_ready) begin
            if (m_stall || !if_valid) begin
                e_valid = 1'b0;
            end else if (!m_pending && opc[4]) begin
                m_pending = 1'b1; m_first = if_word; e_valid = 1'b0;
            end else begin
                e_valid = 1'b1;
                e_opc   = opc;
                e_rd    = w[10:8];
                e_op1   = operand(rs1);
                e_op2   = operand(rs2);
                e_imm   = m_pending ? if_word : 16'h0;
                e_wb    = (opc != 5'd0) && (opc[3:2] != 2'b11);
                e_ld    = (opc == 5'b10100);
                m_pending = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        mem_valid = 0; mem_wb_en = 0; mem_rd = 0; mem_result = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h0101 * (i + 1));
        rf[3] = 16'h0000;
        rst = 1; if_valid = 0; if_word = 0; flush = 0; ex_ready = 1;
        clear_fwd();

        // Reset held for two cycles
        tick(); tick();
        check("rst_regs", 64'({id_valid, id_opcode, id_rd, id_wb_en, id_is_load, id_op1, id_op2, id_imm}), 64'd0);
        check("rst_ready", 64'(if_ready), 64'd0);
        rst = 0; #1;
        check("rel_ready", 64'(if_ready), 64'd1);

        // Plain one-word op: opcode 1, rd 1, rs1 2, rs2 4
        if_valid = 1; if_word = 16'h0950; tick(); if_valid = 0;
        check("add_regs", 64'({id_valid, id_opcode, id_rd, id_wb_en, id_is_load, id_op1, id_op2, id_imm}),
              64'({1'b1, 5'd1, 3'd1, 1'b1, 1'b0, 16'h0303, 16'h0505, 16'h0000}));

        // EX result needed by rs1
        ex_valid = 1; ex_wb_en = 1; ex_rd = 3; ex_result = 16'h1234;
        if_valid = 1; if_word = 16'h0D60;
`ifdef DECODE_FWD_EN
        tick();
        check("exfwd_op1", 64'({id_valid, id_op1}), 64'({1'b1, 16'h1234}));
`else
        #1 check("raw_stall_ready", 64'(if_ready), 64'd0);
        tick(); check("raw_bubble1", 64'(id_valid), 64'd0);
        tick(); check("raw_bubble2", 64'(id_valid), 64'd0);
        ex_valid = 0; #1;
        check("raw_clear_ready", 64'(if_ready), 64'd1);
        tick();
        check("raw_op1_rf", 64'({id_valid, id_op1}), 64'({1'b1, 16'h0000}));
`endif
        if_valid = 0; clear_fwd(); tick();

        // EX wins over MEM for the same register; non-writing EX is ignored
        ex_valid = 1; ex_wb_en = 1; ex_rd = 2; ex_result = 16'hAAAA;
        mem_valid = 1; mem_wb_en = 1; mem_rd = 2; mem_result = 16'hBBBB;
        if_valid = 1; if_word = 16'h0950;
`ifdef DECODE_FWD_EN
        tick(); check("prio_op1", 64'(id_op1), 64'h0000_AAAA);
`else
        tick(); check("prio_bubble", 64'(id_valid), 64'd0);
        clear_fwd(); tick(); check("prio_op1_rf", 64'(id_op1), 64'h0000_0303);
`endif
        clear_fwd();
        ex_valid = 1; ex_wb_en = 0; ex_rd = 2; ex_result = 16'hAAAA;
        tick(); check("nowb_ex_op1", 64'({id_valid, id_op1}), 64'({1'b1, 16'h0303}));
        if_valid = 0; clear_fwd(); tick();

        // Load-use on rs2, then the load's data arrives from MEM
        ex_valid = 1; ex_is_load = 1; ex_wb_en = 1; ex_rd = 2; ex_result = 16'hDEAD;
        if_valid = 1; if_word = 16'h1128;
        #1 check("lu_ready", 64'(if_ready), 64'd0);
        tick(); check("lu_bubble", 64'(id_valid), 64'd0);
        clear_fwd(); mem_valid = 1; mem_wb_en = 1; mem_rd = 2; mem_result = 16'hCAFE;
`ifdef DECODE_FWD_EN
        #1 check("lu_ready2", 64'(if_ready), 64'd1);
        tick(); check("lu_op2_mem", 64'({id_valid, id_op2}), 64'({1'b1, 16'hCAFE}));
`else
        tick(); check("lu_bubble2", 64'(id_valid), 64'd0);
        clear_fwd();
        tick(); check("lu_op2_rf", 64'({id_valid, id_op2}), 64'({1'b1, 16'h0303}));
`endif
        if_valid = 0; clear_fwd(); tick();

        // Two-word LDD: opcode 10100, rs1 7, rs2 1, immediate BEEF
        if_valid = 1; if_word = 16'hA0E4; tick();
        check("ldd_wait", 64'(id_valid), 64'd0);
        if_word = 16'hBEEF; #1;
        check("ldd_addr_hold", 64'({rf_addr1, rf_addr2}), 64'({3'd7, 3'd1}));
        tick();
        check("ldd_regs", 64'({id_valid, id_opcode, id_wb_en, id_is_load, id_op1, id_imm}),
              64'({1'b1, 5'b10100, 1'b1, 1'b1, 16'h0808, 16'hBEEF}));

        // Flush while waiting for an immediate
        if_word = 16'h8A2C; tick();
        flush = 1; if_word = 16'h1234; tick(); flush = 0;
        check("flush_valid", 64'(id_valid), 64'd0);
        if_word = 16'h0950; #1;
        check("flush_addr", 64'(rf_addr1), 64'd2);
        tick();
        check("flush_next", 64'({id_valid, id_opcode, id_imm}), 64'({1'b1, 5'd1, 16'h0000}));

        // EX back-pressure holds the ID/EX register
        ex_ready = 0; if_word = 16'h1128; #1;
        check("bp_ready", 64'(if_ready), 64'd0);
        tick(); check("bp_hold", 64'({id_valid, id_opcode}), 64'({1'b1, 5'd1}));
        ex_ready = 1; tick();
        check("bp_release", 64'({id_valid, id_opcode}), 64'({1'b1, 5'd2}));

        // No-writeback class, and NOP never stalls
        if_word = 16'h6394; tick();
        check("nowb_class", 64'({id_valid, id_wb_en}), 64'({1'b1, 1'b0}));
        ex_valid = 1; ex_is_load = 1; ex_wb_en = 1; ex_rd = 0; if_word = 16'h0000; #1;
        check("nop_ready", 64'(if_ready), 64'd1);
        tick(); check("nop_regs", 64'({id_valid, id_wb_en, id_is_load}), 64'({1'b1, 1'b0, 1'b0}));
        clear_fwd();

        // Reset in the middle of a two-word instruction
        if_word = 16'h8A2C; tick();
        rst = 1; if_valid = 0; tick();
        check("midrst_regs", 64'({id_valid, id_opcode, id_op1, id_imm}), 64'd0);
        check("midrst_ready", 64'(if_ready), 64'd0);
        rst = 0; if_valid = 1; if_word = 16'h0950; tick();
        check("midrst_next", 64'({id_valid, id_opcode, id_imm}), 64'({1'b1, 5'd1, 16'h0000}));

        // Load-use stall on the immediate word
        if_word = 16'h8A2C; tick();
        ex_valid = 1; ex_is_load = 1; ex_wb_en = 1; ex_rd = 3; if_word = 16'hCAFE; #1;
        check("imm_lu_ready", 64'(if_ready), 64'd0);
        tick(); check("imm_lu_bubble", 64'(id_valid), 64'd0);
        clear_fwd(); tick();
        check("imm_lu_regs", 64'({id_valid, id_opcode, id_op2, id_imm}),
              64'({1'b1, 5'b10001, 16'h0000, 16'hCAFE}));

        if_valid = 0; tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  pipeline clock, all state on posedge; register file writes on negedge of the same clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_valid  in  1  / if_word  in  16  / if_ready  out  1: fetch handshake; a word is consumed on a cycle with if_valid && if_ready.
REQ-004 rf_addr1, rf_addr2  out  3: register file read addresses; rf_data1, rf_data2  in  16: asynchronous read data.
REQ-005 ex_valid, ex_wb_en, ex_is_load  in  1; ex_rd  in  3; ex_result  in  16: instruction currently in EX.
REQ-006 mem_valid, mem_wb_en  in  1; mem_rd  in  3; mem_result  in  16: instruction currently in MEM.
REQ-007 flush  in  1: branch redirect; ex_ready  in  1: EX accepts the ID/EX register this cycle.
REQ-008 id_valid  out  1; id_opcode  out  5; id_rd  out  3; id_op1, id_op2, id_imm  out  16; id_wb_en, id_is_load  out  1: ID/EX pipeline register.

Function
REQ-009 Word format: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] ignored; opcode[4]=1 marks a two-word instruction whose next fetched word is a 16-bit immediate.
REQ-010 Decode: opcode 5'b00000 = NOP, id_wb_en=0; opcode[3:2]=2'b11 = no writeback; id_is_load=1 only for OP_LDD (5'b10100); all other opcodes set id_wb_en=1.
REQ-011 FSM states: S_OP (expect instruction word), S_IMM (expect immediate); S_OP -> S_IMM on accepting a word with opcode[4]=1; S_IMM -> S_OP on accepting the immediate.
REQ-012 In S_IMM the opcode/rd/rs1/rs2 fields of the held instruction are kept in an internal holding register; the ID/EX register is loaded only when the immediate is accepted; id_imm=0 for one-word instructions.
REQ-013 rf_addr1/rf_addr2 are driven from the current word in S_OP and from the holding register in S_IMM.
REQ-014 Operand select per source (priority high to low): EX forward if ex_valid && ex_wb_en && !ex_is_load && ex_rd==rs; MEM forward if mem_valid && mem_wb_en && mem_rd==rs; else rf_data.
REQ-015 Load-use stall: if ex_valid && ex_is_load && ex_rd equals rs1 or rs2 of a non-NOP instruction being completed, if_ready=0 and id_valid is loaded with 0 (bubble) for that cycle; no word is consumed.
REQ-016 if_ready = ex_ready && !stall; when ex_ready=0 the ID/EX register and FSM hold unchanged.
REQ-017 Latency: one cycle from accepting the final word of an instruction to id_valid=1.
REQ-018 flush has priority over stall and ex_ready: next cycle id_valid=0, FSM=S_OP, holding register cleared, incoming word discarded.
REQ-019 Writeback-stage results need no forwarding: the negedge register file write makes them visible on rf_data in the same cycle.

Reset
REQ-020 While rst=1 at posedge: FSM=S_OP, id_valid=0, id_wb_en=0, id_is_load=0, id_opcode=0, id_rd=0, id_op1=id_op2=id_imm=0, holding register=0; if_ready=0 during reset.
REQ-021 rst mid two-word instruction abandons it; the first word after reset is decoded as an opcode.

Configuration
REQ-022 Macro DECODE_FWD_EN: defined -> REQ-014 forwarding active; undefined -> operands always from rf_data and any RAW match against a valid writing EX or MEM instruction stalls as in REQ-015 until it clears.

Structure
REQ-023 Package mznm_pkg holds opcode width, OP_NOP/OP_LDD constants, the no-writeback class code and the fsm state typedef.
REQ-024 One sub-module, operand_fwd_mux, instantiated twice, implements REQ-014 for one source.

Verification
REQ-025 Reset: rst=1 two cycles -> all outputs zero, if_ready=0; release -> if_ready=1.
REQ-026 EX forward: ex_rd=3, ex_result=16'h1234, ex_wb_en=1, instruction reads rs1=3 with rf_data1=0 -> id_op1=16'h1234 next cycle.
REQ-027 Load-use: ex_is_load=1, ex_rd=2, instruction rs2=2 -> one bubble (id_valid=0), if_ready=0 one cycle, then id_valid=1 with id_op2 from MEM forward.
REQ-028 Two-word: word 16'hA0E4 (opcode 5'b10100) then 16'hBEEF -> S_IMM for one cycle, then id_is_load=1, id_imm=16'hBEEF.
REQ-029 flush asserted in S_IMM -> next cycle id_valid=0, FSM=S_OP; next word decoded as opcode.
REQ-030 DECODE_FWD_EN undefined: REQ-026 stimulus -> stall until ex_valid=0, then id_op1 from rf_data1.
